// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the 3x3 window generator.
// Window element i = r*CONV_K + c, r=0 top (oldest row), c=0 left (oldest column).
package conv_window_gen_pkg;

    localparam int CONV_K       = 3;
    localparam int CONV_WIN_NUM = CONV_K * CONV_K;

    function automatic int win_idx(input int r, input int c);
        return r * CONV_K + c;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay line, read-before-write, registered read data.
// Latency 1 cycle from rd_addr to rd_data; no backpressure.
module conv_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int AW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to packed 3x3 sliding windows (valid padding, stride 1).
// Latency 1 cycle from accepted pixel to window; no backpressure.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int DATA_WIDTH  = 8,
    localparam int WIN_NUM    = CONV_WIN_NUM
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         pix_data_in,
    input  logic                          pix_valid_in,
    input  logic                          pix_sof_in,
    output logic [WIN_NUM*DATA_WIDTH-1:0] win_data_out,
    output logic                          win_valid_out,
    output logic                          frame_done_out
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col, col_eff, col_nxt;
    logic [RW-1:0] row, row_eff, row_nxt;
    logic          accept;

    logic [DATA_WIDTH-1:0] lb0_q, lb1_q;
    logic [DATA_WIDTH-1:0] win [CONV_K][CONV_K];

    assign accept = pix_valid_in & rstn;

    // SOF forces the pixel to (0,0); the abandoned frame can never reach its last pixel.
    always_comb begin
        col_eff = pix_sof_in ? '0 : col;
        row_eff = pix_sof_in ? '0 : row;
        col_nxt = col;
        row_nxt = row;
        if (!rstn) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (pix_valid_in) begin
            if (col_eff == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col_nxt = col_eff + 1'b1;
                row_nxt = row_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        col <= col_nxt;
        row <= row_nxt;
    end

    // Reads are prefetched at the next pixel's column so the registered read data
    // is already present when that pixel arrives, keeping latency at one cycle.
    conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .wr_addr (col_eff),
        .rd_addr (col_nxt),
        .wr_data (pix_data_in),
        .rd_data (lb0_q)
    );

    conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .wr_addr (col_eff),
        .rd_addr (col_nxt),
        .wr_data (lb0_q),
        .rd_data (lb1_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            win_valid_out  <= 1'b0;
            frame_done_out <= 1'b0;
            for (int r = 0; r < CONV_K; r++) begin
                for (int c = 0; c < CONV_K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            win_valid_out  <= pix_valid_in && (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
            frame_done_out <= pix_valid_in && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
            if (pix_valid_in) begin
                for (int r = 0; r < CONV_K; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1_q;
                win[1][2] <= lb0_q;
                win[2][2] <= pix_data_in;
            end
        end
    end

    always_comb begin
        win_data_out = '0;
        for (int r = 0; r < CONV_K; r++) begin
            for (int c = 0; c < CONV_K; c++) begin
                win_data_out[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 8x8 instance for frame scenarios, 3x3 instance for the minimum size.
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic [71:0] win_data;
    logic        win_valid;
    logic        frame_done;

    logic [7:0]  pix2_data;
    logic        pix2_valid;
    logic        pix2_sof;
    logic [71:0] win2_data;
    logic        win2_valid;
    logic        frame2_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pix_data_in    (pix_data),
        .pix_valid_in   (pix_valid),
        .pix_sof_in     (pix_sof),
        .win_data_out   (win_data),
        .win_valid_out  (win_valid),
        .frame_done_out (frame_done)
    );

    conv_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_WIDTH(8)) dut3 (
        .clk            (clk),
        .rstn           (rstn),
        .pix_data_in    (pix2_data),
        .pix_valid_in   (pix2_valid),
        .pix_sof_in     (pix2_sof),
        .win_data_out   (win2_data),
        .win_valid_out  (win2_valid),
        .frame_done_out (frame2_done)
    );

    // Expected 8x8 ramp window ending at pixel (r,c); value = off + row*8 + col.
    function automatic logic [71:0] exp_win(input int r, input int c, input int off);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                w[(rr*3+cc)*8 +: 8] = 8'(off + (r - 2 + rr) * 8 + (c - 2 + cc));
            end
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        pix_valid = v;
        pix_data  = d;
        pix_sof   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        pix2_valid = v;
        pix2_data  = d;
        pix2_sof   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        pix_valid = 1'b0; pix_data = 8'h0; pix_sof = 1'b0;
        pix2_valid = 1'b0; pix2_data = 8'h0; pix2_sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", win_valid); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        total++;
        if (win_data !== 72'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", win_data); end
        total++;
        if (win2_valid !== 1'b0 || win2_data !== 72'h0) begin
            bad++; $display("FAIL reset_dut3 valid=%b data=%h exp 0/0", win2_valid, win2_data);
        end
        rstn = 1'b1;
    endtask

    task automatic test_ramp();
        int nwin = 0;
        for (int p = 0; p < 64; p++) begin
            int r, c;
            logic ev, ed;
            r = p / 8; c = p % 8;
            ev = (r >= 2 && c >= 2);
            ed = (p == 63);
            drive(1'b1, 8'(p), p == 0);
            total++;
            if (win_valid !== ev || frame_done !== ed || (ev && win_data !== exp_win(r, c, 0))) begin
                bad++;
                $display("FAIL ramp p=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h",
                         p, win_valid, frame_done, win_data, ev, ed, exp_win(r, c, 0));
            end
            if (win_valid === 1'b1) nwin++;
        end
        total++;
        if (nwin != 36) begin bad++; $display("FAIL ramp_count got=%0d exp=36", nwin); end
        drive(1'b0, 8'h55, 1'b0);
        total++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== exp_win(7, 7, 0)) begin
            bad++; $display("FAIL ramp_idle got v=%b d=%b w=%h exp v=0 d=0 w=%h",
                            win_valid, frame_done, win_data, exp_win(7, 7, 0));
        end
    endtask

    task automatic test_gaps();
        int p = 0, nwin = 0, lr = 0, lc = 0;
        while (p < 64) begin
            if ($urandom_range(0, 99) < 40) begin
                drive(1'b0, 8'hEE, 1'b1);
                total++;
                if (win_valid !== 1'b0 || frame_done !== 1'b0 ||
                    (lr >= 2 && lc >= 2 && win_data !== exp_win(lr, lc, 0))) begin
                    bad++; $display("FAIL gap_idle p=%0d got v=%b d=%b w=%h exp v=0 d=0 w=%h",
                                    p, win_valid, frame_done, win_data, exp_win(lr, lc, 0));
                end
            end else begin
                logic ev, ed;
                lr = p / 8; lc = p % 8;
                ev = (lr >= 2 && lc >= 2);
                ed = (p == 63);
                drive(1'b1, 8'(p), p == 0);
                total++;
                if (win_valid !== ev || frame_done !== ed || (ev && win_data !== exp_win(lr, lc, 0))) begin
                    bad++; $display("FAIL gap_pix p=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h",
                                    p, win_valid, frame_done, win_data, ev, ed, exp_win(lr, lc, 0));
                end
                if (win_valid === 1'b1) nwin++;
                p++;
            end
        end
        total++;
        if (nwin != 36) begin bad++; $display("FAIL gap_count got=%0d exp=36", nwin); end
    endtask

    task automatic test_back_to_back();
        int nwin = 0, ndone = 0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 64; p++) begin
                int r, c;
                logic ev, ed;
                r = p / 8; c = p % 8;
                ev = (r >= 2 && c >= 2);
                ed = (p == 63);
                drive(1'b1, 8'(f * 100 + p), p == 0);
                total++;
                if (win_valid !== ev || frame_done !== ed || (ev && win_data !== exp_win(r, c, f * 100))) begin
                    bad++; $display("FAIL b2b f=%0d p=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h",
                                    f, p, win_valid, frame_done, win_data, ev, ed, exp_win(r, c, f * 100));
                end
                if (win_valid === 1'b1) nwin++;
                if (frame_done === 1'b1) ndone++;
            end
        end
        total++;
        if (nwin != 72 || ndone != 2) begin
            bad++; $display("FAIL b2b_count got win=%0d done=%0d exp win=72 done=2", nwin, ndone);
        end
    endtask

    task automatic test_mid_sof();
        int ndone = 0, nwin = 0;
        for (int p = 0; p < 35; p++) begin
            int r, c;
            logic ev;
            r = p / 8; c = p % 8;
            ev = (r >= 2 && c >= 2);
            drive(1'b1, 8'(p), p == 0);
            total++;
            if (win_valid !== ev || frame_done !== 1'b0 || (ev && win_data !== exp_win(r, c, 0))) begin
                bad++; $display("FAIL sof_old p=%0d got v=%b d=%b w=%h exp v=%b d=0 w=%h",
                                p, win_valid, frame_done, win_data, ev, exp_win(r, c, 0));
            end
        end
        for (int p = 0; p < 64; p++) begin
            int r, c;
            logic ev, ed;
            r = p / 8; c = p % 8;
            ev = (r >= 2 && c >= 2);
            ed = (p == 63);
            drive(1'b1, 8'(p), p == 0);
            total++;
            if (win_valid !== ev || frame_done !== ed || (ev && win_data !== exp_win(r, c, 0))) begin
                bad++; $display("FAIL sof_new p=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h",
                                p, win_valid, frame_done, win_data, ev, ed, exp_win(r, c, 0));
            end
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
        end
        total++;
        if (nwin != 36 || ndone != 1) begin
            bad++; $display("FAIL sof_count got win=%0d done=%0d exp win=36 done=1", nwin, ndone);
        end
    endtask

    task automatic test_reset_mid();
        int nwin = 0;
        for (int p = 0; p < 45; p++) drive(1'b1, 8'(p), p == 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rstn = 1'b0; pix_valid = 1'b1; pix_data = 8'd45; pix_sof = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== 72'h0) begin
                bad++; $display("FAIL rst_mid k=%0d got v=%b d=%b w=%h exp all 0",
                                k, win_valid, frame_done, win_data);
            end
        end
        rstn = 1'b1;
        for (int p = 0; p < 64; p++) begin
            int r, c;
            logic ev, ed;
            r = p / 8; c = p % 8;
            ev = (r >= 2 && c >= 2);
            ed = (p == 63);
            drive(1'b1, 8'(p), 1'b0);
            total++;
            if (win_valid !== ev || frame_done !== ed || (ev && win_data !== exp_win(r, c, 0))) begin
                bad++; $display("FAIL rst_after p=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h",
                                p, win_valid, frame_done, win_data, ev, ed, exp_win(r, c, 0));
            end
            if (win_valid === 1'b1) nwin++;
        end
        total++;
        if (nwin != 36) begin bad++; $display("FAIL rst_count got=%0d exp=36", nwin); end
        drive(1'b0, 8'h0, 1'b0);
    endtask

    task automatic test_width3();
        logic [71:0] w3;
        for (int i = 0; i < 9; i++) w3[i*8 +: 8] = 8'(i + 1);
        for (int k = 1; k <= 9; k++) begin
            logic ev;
            ev = (k == 9);
            drive3(1'b1, 8'(k), k == 1);
            total++;
            if (win2_valid !== ev || frame2_done !== ev || (ev && win2_data !== w3)) begin
                bad++; $display("FAIL w3 k=%0d got v=%b d=%b w=%h exp v=%b d=%b w=%h",
                                k, win2_valid, frame2_done, win2_data, ev, ev, w3);
            end
        end
        drive3(1'b0, 8'h0, 1'b0);
        total++;
        if (win2_valid !== 1'b0 || frame2_done !== 1'b0) begin
            bad++; $display("FAIL w3_idle got v=%b d=%b exp 0/0", win2_valid, frame2_done);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_back_to_back();
        test_mid_sof();
        test_reset_mid();
        test_width3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Upstream feeder for the convolution unit. Consumes a raster-ordered single-channel pixel stream, one pixel per cycle at most. Buffers the two previous image rows and emits a 3x3 sliding window (valid padding, stride 1) packed to drive `MAC_data_in` / `MAC_data_valid_in` directly. The stream has no backpressure, because the convolution unit has no ready.

## Interface
Parameters:
- `IMG_WIDTH`, 32: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, 32: rows per frame; must be ≥ 3.
- `DATA_WIDTH`, 8: pixel width; matches the MAC data width.
- `WIN_NUM`, 9: window size (3x3); fixed, not overridable.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `pix_data_in`  in  DATA_WIDTH  input pixel.
- `pix_valid_in`  in  1  pixel qualifier; one pixel accepted per cycle when high.
- `pix_sof_in`  in  1  start of frame; meaningful only with `pix_valid_in`.
- `win_data_out`  out  WIN_NUM*DATA_WIDTH  window; connects to `MAC_data_in`.
- `win_valid_out`  out  1  window qualifier; connects to `MAC_data_valid_in`.
- `frame_done_out`  out  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- **Position counters.** `col` ranges 0..IMG_WIDTH-1 and `row` ranges 0..IMG_HEIGHT-1. They give the position of the next accepted pixel.
  - `col` advances on each accepted pixel.
  - At `col`=IMG_WIDTH-1, `col` wraps to 0 and `row` increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0. Back-to-back frames need no bubble.
- **SOF handling.** An accepted pixel with `pix_sof_in`=1 is treated as (0,0) regardless of the counters. Counters then continue from (0,1).
  - If the counters were not already at (0,0), the partial frame is discarded.
  - A discarded frame produces no `frame_done_out`.
  - `pix_sof_in` without `pix_valid_in` is ignored.
- **Line buffers.** Two one-row delay lines, each IMG_WIDTH deep, addressed by `col`.
  - Buffer 0 writes the incoming pixel and reads row-1 at the same column.
  - Buffer 1 writes buffer 0's read data and reads row-2.
  - Buffers are read-before-write at the same address in the same cycle.
  - Buffer contents are never cleared. Stale data is masked by the validity rule below.
- **Window register.** 3x3 registers. On each accepted pixel, all columns shift left and the new right column becomes {row-2 pixel, row-1 pixel, current pixel}.
- **Packing.** Element `i` = r*3+c occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
  - r=0 is the oldest row (top); c=0 is the oldest column (left).
  - Element 8 is the pixel just accepted.
- **Validity.** The window is valid for an accepted pixel at (row,col) with row ≥ 2 and col ≥ 2. No windows straddle rows or frames. A frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- **Frame done.** `frame_done_out` pulses with the window for pixel (IMG_HEIGHT-1, IMG_WIDTH-1). It is asserted only if that frame was not aborted by a mid-frame SOF.

## Timing
- Latency is 1 cycle. The window completed by a pixel accepted at cycle N appears on `win_data_out` with `win_valid_out`=1 at cycle N+1.
- On an idle cycle (`pix_valid_in`=0), there is no shift and no counter change. `win_valid_out` and `frame_done_out` are 0 in the next cycle. `win_data_out` holds its last value.
- Reset values: `win_valid_out`=0, `frame_done_out`=0, `win_data_out`=0, window registers=0, `row`=`col`=0.
- If `rstn`=0 coincides with `pix_valid_in`=1, reset wins and the pixel is dropped.
- Reset mid-frame aborts the frame. The next accepted pixel is (0,0) whether or not SOF is set.
- Sustained throughput is one window per cycle inside the valid region.

## Structure
- Shared package holds:
  - `CONV_K`=3 and `CONV_WIN_NUM`=9;
  - the window element index convention (r*3+c);
  - the counter-width helper, $clog2 of IMG_WIDTH / IMG_HEIGHT.
- Sub-module `conv_line_buffer`: a single-row delay, parameterised by depth and width.
  - Inputs: write-enable, address, data in. Output: registered read data.
  - Read-before-write; maps to block RAM or distributed RAM.
  - Instantiated twice.
- Top level holds the position counters, SOF handling, window shift register, and valid/done logic.

## Test plan
- **Ramp frame.** IMG_WIDTH=IMG_HEIGHT=8, pixel value = row*8+col, continuous valid, SOF on pixel 0.
  - The first `win_valid_out` comes 1 cycle after pixel 18, with elements 0..8 = {0,1,2,8,9,10,16,17,18}.
  - Exactly 36 windows; the last is {45,46,47,53,54,55,61,62,63} with `frame_done_out`=1.
- **Random gaps.** Same frame with `pix_valid_in` deasserted about 40% of the time at random.
  - Same 36 windows in the same order.
  - `win_data_out` unchanged during gaps; never a valid during a gap+1 cycle.
- **Back-to-back frames.** Two frames with values offset by 100, no idle between.
  - Second frame's first window = {100,101,102,108,109,110,116,117,118}.
  - No window straddles frames; two `frame_done_out` pulses.
- **Mid-frame SOF.** Assert SOF at pixel (4,3) of frame 1.
  - No `frame_done_out` for frame 1.
  - The restarted frame's first window appears after its own pixel (2,2) and matches the ramp values.
- **Reset mid-frame.** Hold `rstn`=0 for 2 cycles at pixel (5,5) while valid is high.
  - Outputs go to 0 in the cycle after reset is sampled.
  - The next frame, sent without SOF, produces 36 correct windows.
- **Width sweep.** IMG_WIDTH=3, IMG_HEIGHT=3, pixels 1..9.
  - Exactly one window = {1..9} with `frame_done_out`=1.
